iiitb_tdm_demux: RTL and testbench
==================================

IIITB_TDM_DEMUX -- requirements
Module: iiitb_tdm_demux

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 1, bit width of each channel sample.
REQ-002 The module SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have the port rst, input, 1 bit, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The module SHALL have the port en, input, 1 bit, slot strobe; din and sync are sampled only when en=1.
REQ-005 The module SHALL have the port din, input, WIDTH bits, the time-multiplexed sample stream, slot order a, b, c, d.
REQ-006 The module SHALL have the port sync, input, 1 bit, frame marker; high with en during the slot-0 (channel a) sample.
REQ-007 The module SHALL have the ports a, b, c, d, each output, WIDTH bits, the registered demultiplexed channel samples of the last complete frame.
REQ-008 The module SHALL have the port frame_valid, output, 1 bit, a one-cycle pulse when a, b, c, d are updated.
REQ-009 The module SHALL have the port locked, output, 1 bit, high in state LOCKED.
REQ-010 The module SHALL have the port slot, output, 2 bits, the index of the slot expected on the next en cycle.
REQ-011 The module SHALL have the port sync_err, output, 1 bit, a one-cycle pulse on a framing violation.

Function
REQ-012 The module SHALL implement a state machine with the states IDLE and LOCKED, plus a 2-bit slot counter cnt, with slot = cnt.
REQ-013 In IDLE with en=1 and sync=1, the module SHALL store din as shadow slot 0, set cnt=1 and go to LOCKED.
REQ-014 In IDLE, the module SHALL ignore en=1 with sync=0 and leave cnt=0, with no sync_err.
REQ-015 In LOCKED with en=1, sync=0 and cnt in {1,2}, the module SHALL store din into shadow slot cnt and increment cnt.
REQ-016 In LOCKED with en=1, sync=0 and cnt=3, the module SHALL, on the same edge, load a, b, c, d from shadow0, shadow1, shadow2 and din, wrap cnt to 0, and pulse frame_valid for exactly the following cycle.
REQ-017 In LOCKED with en=1, sync=1 and cnt=0, the module SHALL store din as shadow slot 0 and set cnt=1; this is a normal frame start.
REQ-018 In LOCKED with en=1, sync=1 and cnt!=0 (early sync), the module SHALL discard the partial frame, pulse sync_err, store din as shadow slot 0, set cnt=1 and remain LOCKED, leaving a–d unchanged.
REQ-019 In LOCKED with en=1, sync=0 and cnt=0 (missing sync), the module SHALL pulse sync_err, go to IDLE, ignore din, and leave a–d unchanged.
REQ-020 With en=0, the module SHALL hold all state, shadows and a–d; frame_valid and sync_err SHALL be 0.
REQ-021 The outputs a–d SHALL change only on frame completion (REQ-016) or reset.
REQ-022 Latency SHALL be one clock from the slot-3 sampling edge to the cycle in which new a–d and frame_valid are visible.
REQ-023 When sync=1 without en, the module SHALL ignore it.

Reset
REQ-024 On rst=1 at a clock edge, the module SHALL set state=IDLE, cnt=0, shadows=0, a=b=c=d=0, frame_valid=0, sync_err=0 and locked=0, regardless of en, sync or din.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first frame after reset SHALL require a new sync.

Verification
REQ-026 The bench SHALL cover this scenario: WIDTH=4, en=1 continuously, with sync on the first of din=3,5,9,C -> one cycle later a=3, b=5, c=9, d=C, frame_valid=1 for 1 cycle, locked=1, slot=0.
REQ-027 The bench SHALL cover this scenario: two back-to-back frames 1,2,3,4 then 5,6,7,8, each with sync on slot 0 -> frame_valid pulses exactly 4 cycles apart, a–d=1,2,3,4 then 5,6,7,8, sync_err never set.
REQ-028 The bench SHALL cover this scenario: en toggling 1/0 every cycle during a frame -> the same a–d as with continuous en, frame_valid 1 cycle after the 4th en-high sample, and no captures on en=0 cycles.
REQ-029 The bench SHALL cover this scenario: sync reasserted at slot 2 of a frame -> sync_err pulse, a–d unchanged, the next three samples complete a new frame with frame_valid.
REQ-030 The bench SHALL cover this scenario: sync omitted at a frame boundary -> sync_err pulse, locked=0, slot=0, and no frame_valid until the next sync.
REQ-031 The bench SHALL cover this scenario: rst=1 asserted with cnt=2 -> next cycle a–d=0, locked=0, slot=0, and a subsequent frame without sync is ignored.

Source files
------------

// File: rtl/iiitb_tdm_demux.sv
// Four-channel TDM demultiplexer: frame-locks on sync, gathers slots a..d, publishes whole frames.
// Latency: a-d and frame_valid appear one clock after the slot-3 sample; no backpressure, en strobes each slot.
module iiitb_tdm_demux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    output logic             locked,
    output logic [1:0]       slot,
    output logic             sync_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_d;
    logic             r_fv;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_fv    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_fv  <= 1'b0;
            r_err <= 1'b0;
            if (en) begin
                case (r_state)
                    IDLE: begin
                        if (sync) begin
                            r_sh0   <= din;
                            r_cnt   <= 2'd1;
                            r_state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (sync) begin
                            // A sync anywhere but slot 0 drops the partial frame and restarts it
                            r_err <= (r_cnt != 2'd0);
                            r_sh0 <= din;
                            r_cnt <= 2'd1;
                        end else begin
                            case (r_cnt)
                                2'd0: begin
                                    r_err   <= 1'b1;
                                    r_state <= IDLE;
                                end
                                2'd1: begin
                                    r_sh1 <= din;
                                    r_cnt <= 2'd2;
                                end
                                2'd2: begin
                                    r_sh2 <= din;
                                    r_cnt <= 2'd3;
                                end
                                default: begin
                                    r_a   <= r_sh0;
                                    r_b   <= r_sh1;
                                    r_c   <= r_sh2;
                                    r_d   <= din;
                                    r_cnt <= 2'd0;
                                    r_fv  <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign a           = r_a;
    assign b           = r_b;
    assign c           = r_c;
    assign d           = r_d;
    assign frame_valid = r_fv;
    assign sync_err    = r_err;
    assign locked      = (r_state == LOCKED);
    assign slot        = r_cnt;

endmodule

// File: tb/tb_iiitb_tdm_demux.sv
// Bench for iiitb_tdm_demux: directed framing scenarios then random traffic against a queue-based frame model.
module tb_iiitb_tdm_demux;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, sync;
    logic [W-1:0] din;
    logic [W-1:0] a, b, c, d;
    logic         frame_valid, locked, sync_err;
    logic [1:0]   slot;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference: a frame is the list of samples gathered since the last sync.
    logic [W-1:0] m_frame[$];
    bit           m_locked;
    logic [W-1:0] m_a, m_b, m_c, m_d;
    bit           m_fv, m_err;

    iiitb_tdm_demux #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .a(a), .b(b), .c(c), .d(d),
        .frame_valid(frame_valid), .locked(locked), .slot(slot), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit s, input logic [W-1:0] dn);
        m_fv  = 0;
        m_err = 0;
        if (r) begin
            m_frame.delete();
            m_locked = 0;
            m_a = '0; m_b = '0; m_c = '0; m_d = '0;
        end else if (e) begin
            if (!m_locked) begin
                if (s) begin
                    m_frame = {dn};
                    m_locked = 1;
                end
            end else if (s) begin
                if (m_frame.size() != 0) m_err = 1;
                m_frame = {dn};
            end else if (m_frame.size() == 0) begin
                m_err = 1;
                m_locked = 0;
            end else begin
                m_frame.push_back(dn);
                if (m_frame.size() == 4) begin
                    m_a = m_frame[0]; m_b = m_frame[1];
                    m_c = m_frame[2]; m_d = m_frame[3];
                    m_fv = 1;
                    m_frame.delete();
                end
            end
        end
    endtask

    task automatic step(input string tag, input bit r, input bit e, input bit s, input logic [W-1:0] dn);
        rst = r; en = e; sync = s; din = dn;
        @(posedge clk);
        model(r, e, s, dn);
        #1;
        chk({tag, ".a"}, 32'(a), 32'(m_a));
        chk({tag, ".b"}, 32'(b), 32'(m_b));
        chk({tag, ".c"}, 32'(c), 32'(m_c));
        chk({tag, ".d"}, 32'(d), 32'(m_d));
        chk({tag, ".fv"}, 32'(frame_valid), 32'(m_fv));
        chk({tag, ".err"}, 32'(sync_err), 32'(m_err));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        chk({tag, ".slot"}, 32'(slot), 32'(m_frame.size()));
    endtask

    task automatic frame(input string tag, input logic [W-1:0] s0, s1, s2, s3);
        step(tag, 0, 1, 1, s0);
        step(tag, 0, 1, 0, s1);
        step(tag, 0, 1, 0, s2);
        step(tag, 0, 1, 0, s3);
    endtask

    initial begin
        rst = 1; en = 0; sync = 0; din = '0;
        step("reset", 1, 1, 1, 4'hF);
        chk("reset.a0", 32'(a), 32'h0);
        chk("reset.locked0", 32'(locked), 32'h0);

        // Basic frame with continuous en
        frame("f359c", 4'h3, 4'h5, 4'h9, 4'hC);
        chk("f359c.a3", 32'(a), 32'h3);
        chk("f359c.dC", 32'(d), 32'hC);
        chk("f359c.fv1", 32'(frame_valid), 32'h1);
        chk("f359c.slot0", 32'(slot), 32'h0);

        // Back-to-back frames
        frame("b2b1", 4'h1, 4'h2, 4'h3, 4'h4);
        frame("b2b2", 4'h5, 4'h6, 4'h7, 4'h8);
        chk("b2b2.b6", 32'(b), 32'h6);

        // en toggling; sync/din on en=0 cycles must be ignored
        step("tog", 0, 1, 1, 4'hA);
        step("tog", 0, 0, 1, 4'h0);
        step("tog", 0, 1, 0, 4'hB);
        step("tog", 0, 0, 0, 4'h1);
        step("tog", 0, 1, 0, 4'hC);
        step("tog", 0, 0, 1, 4'h2);
        step("tog", 0, 1, 0, 4'hD);
        chk("tog.fv1", 32'(frame_valid), 32'h1);
        chk("tog.aA", 32'(a), 32'hA);
        step("tog", 0, 0, 0, 4'h3);
        chk("tog.fv0", 32'(frame_valid), 32'h0);

        // Early sync at slot 2
        step("early", 0, 1, 1, 4'h1);
        step("early", 0, 1, 0, 4'h2);
        step("early", 0, 1, 1, 4'h9);
        chk("early.err1", 32'(sync_err), 32'h1);
        chk("early.aA", 32'(a), 32'hA);
        step("early", 0, 1, 0, 4'h8);
        step("early", 0, 1, 0, 4'h7);
        step("early", 0, 1, 0, 4'h6);
        chk("early.a9", 32'(a), 32'h9);

        // Missing sync at frame boundary, then unsynced data ignored
        step("miss", 0, 1, 0, 4'h4);
        chk("miss.err1", 32'(sync_err), 32'h1);
        chk("miss.locked0", 32'(locked), 32'h0);
        for (int i = 0; i < 5; i++) step("miss", 0, 1, 0, 4'(i));
        frame("relock", 4'hE, 4'hD, 4'hC, 4'hB);

        // Reset mid-frame with cnt=2, then frame without sync ignored
        step("rst2", 0, 1, 1, 4'h1);
        step("rst2", 0, 1, 0, 4'h2);
        chk("rst2.slot2", 32'(slot), 32'h2);
        step("rst2", 1, 1, 0, 4'h3);
        chk("rst2.d0", 32'(d), 32'h0);
        for (int i = 0; i < 4; i++) step("nosync", 0, 1, 0, 4'(i + 5));

        // Random traffic
        for (int i = 0; i < 600; i++)
            step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), 4'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
